// File: rtl/match_game_pkg.sv
// Shared types and helpers for the 4-tile colour-matching game.
// Tile index 0..3 corresponds to tiles A..D.
package match_game_pkg;

  typedef enum logic [1:0] {
    PICK1,
    PICK2,
    SHOW,
    WIN
  } state_t;

  localparam logic [1:0] ACT_HIDDEN = 2'b00;
  localparam logic [1:0] ACT_CURSOR = 2'b01;
  localparam logic [1:0] ACT_REVEAL = 2'b10;

  // A<->D are red, B<->C are blue
  function automatic logic [1:0] pair_of(input logic [1:0] idx);
    logic [1:0] p;
    case (idx)
      2'd0:    p = 2'd3;
      2'd1:    p = 2'd2;
      2'd2:    p = 2'd1;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  // First unmatched tile after cur, wrapping; stays put if none
  function automatic logic [1:0] next_free(
    input logic [1:0] cur,
    input logic [3:0] mat
  );
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k < 4; k++) begin
      idx = cur + 2'(k);
      if (!found && !mat[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/match_game_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and
// a single-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;

  // level only follows sync after DEBOUNCE_CYCLES differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      meta  <= btn;
      sync  <= meta;
      pulse <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync;
        cnt   <= '0;
        pulse <= sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/match_game_ctrl.sv
// Game sequencer for the 4-tile matching display: cursor, picks,
// pair compare, mismatch hold and win screen.
module match_game_ctrl
  import match_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int MISMATCH_HOLD   = 25_000_000
) (
  input  logic       clk25MHz,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_sel,
  output logic [1:0] actionA,
  output logic [1:0] actionB,
  output logic [1:0] actionC,
  output logic [1:0] actionD,
  output logic       winscreen,
  output logic [7:0] attempts
);

  localparam int TW =
    (MISMATCH_HOLD > 1) ? $clog2(MISMATCH_HOLD) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(MISMATCH_HOLD - 1);

  logic nxt_p;
  logic sel_p;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk  (clk25MHz),
    .rst  (rst),
    .btn  (btn_next),
    .pulse(nxt_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_sel (
    .clk  (clk25MHz),
    .rst  (rst),
    .btn  (btn_sel),
    .pulse(sel_p)
  );

  state_t          state_q, state_d;
  logic [1:0]      cur_q, cur_d;
  logic [1:0]      first_q, first_d;
  logic [3:0]      rev_q, rev_d;
  logic [3:0]      mat_q, mat_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      att_q, att_d;
  logic [3:0][1:0] act_q, act_d;
  logic            win_q, win_d;

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      state_q <= PICK1;
      cur_q   <= 2'd0;
      first_q <= 2'd0;
      rev_q   <= '0;
      mat_q   <= '0;
      timer_q <= '0;
      att_q   <= '0;
      act_q   <= {ACT_HIDDEN, ACT_HIDDEN, ACT_HIDDEN, ACT_CURSOR};
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      first_q <= first_d;
      rev_q   <= rev_d;
      mat_q   <= mat_d;
      timer_q <= timer_d;
      att_q   <= att_d;
      act_q   <= act_d;
      win_q   <= win_d;
    end
  end

  // sel_p wins over nxt_p; a dropped nxt_p is not remembered
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    first_d = first_q;
    rev_d   = rev_q;
    mat_d   = mat_q;
    timer_d = timer_q;
    att_d   = att_q;
    unique case (state_q)
      PICK1: begin
        if (sel_p) begin
          if (!mat_q[cur_q]) begin
            rev_d[cur_q] = 1'b1;
            first_d      = cur_q;
            state_d      = PICK2;
          end
        end else if (nxt_p) begin
          cur_d = next_free(cur_q, mat_q);
        end
      end
      PICK2: begin
        if (sel_p) begin
          if (cur_q != first_q && !mat_q[cur_q]) begin
            if (att_q != 8'hFF) begin
              att_d = att_q + 8'd1;
            end
            if (pair_of(first_q) == cur_q) begin
              mat_d[first_q] = 1'b1;
              mat_d[cur_q]   = 1'b1;
              rev_d[first_q] = 1'b0;
              rev_d[cur_q]   = 1'b0;
              state_d        = (&mat_d) ? WIN : PICK1;
            end else begin
              rev_d[cur_q] = 1'b1;
              timer_d      = HOLD_LOAD;
              state_d      = SHOW;
            end
          end
        end else if (nxt_p) begin
          cur_d = next_free(cur_q, mat_q);
        end
      end
      SHOW: begin
        if (timer_q == '0) begin
          rev_d[first_q] = 1'b0;
          rev_d[cur_q]   = 1'b0;
          state_d        = PICK1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WIN: begin
        if (sel_p) begin
          rev_d   = '0;
          mat_d   = '0;
          cur_d   = 2'd0;
          state_d = PICK1;
        end
      end
    endcase
  end

  // Output encoder works from registered flags, one cycle behind
  always_comb begin
    act_d = '0;
    win_d = (state_q == WIN);
    for (int i = 0; i < 4; i++) begin
      if (state_q == WIN || rev_q[i] || mat_q[i]) begin
        act_d[i] = ACT_REVEAL;
      end else if (cur_q == 2'(i)) begin
        act_d[i] = ACT_CURSOR;
      end else begin
        act_d[i] = ACT_HIDDEN;
      end
    end
  end

  assign actionA   = act_q[0];
  assign actionB   = act_q[1];
  assign actionC   = act_q[2];
  assign actionD   = act_q[3];
  assign winscreen = win_q;
  assign attempts  = att_q;

endmodule

// File: tb/tb_match_game_ctrl.sv
// Directed bench for match_game_ctrl with short debounce and hold
// times; expected tile states are worked out by hand per step.
module tb_match_game_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_next;
  logic       btn_sel;
  logic [1:0] actionA;
  logic [1:0] actionB;
  logic [1:0] actionC;
  logic [1:0] actionD;
  logic       winscreen;
  logic [7:0] attempts;

  int n_chk  = 0;
  int n_fail = 0;

  match_game_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MISMATCH_HOLD  (8)
  ) dut (
    .clk25MHz (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .btn_sel  (btn_sel),
    .actionA  (actionA),
    .actionB  (actionB),
    .actionC  (actionC),
    .actionD  (actionD),
    .winscreen(winscreen),
    .attempts (attempts)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_act(input string tag, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] c,
                         input logic [1:0] d);
    chk({tag, ".A"}, {6'd0, actionA}, {6'd0, a});
    chk({tag, ".B"}, {6'd0, actionB}, {6'd0, b});
    chk({tag, ".C"}, {6'd0, actionC}, {6'd0, c});
    chk({tag, ".D"}, {6'd0, actionD}, {6'd0, d});
  endtask

  // Hold long enough for acceptance, then release long enough to settle
  task automatic press(input bit s, input bit n);
    btn_sel  = s;
    btn_next = n;
    repeat (8) @(negedge clk);
    btn_sel  = 1'b0;
    btn_next = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    btn_next = 1'b0;
    btn_sel  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // 1: reset state
    chk_act("reset", 2'b01, 2'b00, 2'b00, 2'b00);
    chk("reset.win", {7'd0, winscreen}, 8'd0);
    chk("reset.att", attempts, 8'd0);

    // 2: cursor movement and wrap
    press(0, 1);
    chk_act("next1", 2'b00, 2'b01, 2'b00, 2'b00);
    press(0, 1);
    press(0, 1);
    press(0, 1);
    chk_act("wrap", 2'b01, 2'b00, 2'b00, 2'b00);

    // 3: mismatch A/B, hold, buttons ignored while shown
    press(1, 0);
    chk_act("pickA", 2'b10, 2'b00, 2'b00, 2'b00);
    press(0, 1);
    chk_act("curB", 2'b10, 2'b01, 2'b00, 2'b00);
    btn_sel = 1'b1;
    repeat (8) @(negedge clk);
    chk_act("show", 2'b10, 2'b10, 2'b00, 2'b00);
    chk("show.att", attempts, 8'd1);
    btn_sel  = 1'b0;
    btn_next = 1'b1;
    repeat (6) @(negedge clk);
    chk_act("show.late", 2'b10, 2'b10, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    chk_act("hidden", 2'b00, 2'b01, 2'b00, 2'b00);
    btn_next = 1'b0;
    repeat (8) @(negedge clk);
    chk_act("show.nxt", 2'b00, 2'b01, 2'b00, 2'b00);

    // 4: match A/D, skip matched A, match B/C, win, new game
    press(0, 1);
    press(0, 1);
    press(0, 1);
    chk_act("backA", 2'b01, 2'b00, 2'b00, 2'b00);
    press(1, 0);
    press(0, 1);
    press(0, 1);
    press(0, 1);
    chk_act("curD", 2'b10, 2'b00, 2'b00, 2'b01);
    press(1, 0);
    chk_act("matchAD", 2'b10, 2'b00, 2'b00, 2'b10);
    chk("matchAD.att", attempts, 8'd2);
    press(0, 1);
    chk_act("skipA", 2'b10, 2'b01, 2'b00, 2'b10);
    press(1, 0);
    press(0, 1);
    chk_act("curC", 2'b10, 2'b10, 2'b01, 2'b10);
    btn_sel = 1'b1;
    repeat (8) @(negedge clk);
    chk("win", {7'd0, winscreen}, 8'd1);
    chk("win.att", attempts, 8'd3);
    chk_act("win", 2'b10, 2'b10, 2'b10, 2'b10);
    btn_sel = 1'b0;
    repeat (8) @(negedge clk);
    press(0, 1);
    chk("win.nxt", {7'd0, winscreen}, 8'd1);
    chk_act("win.nxt", 2'b10, 2'b10, 2'b10, 2'b10);
    press(1, 0);
    chk_act("newgame", 2'b01, 2'b00, 2'b00, 2'b00);
    chk("newgame.win", {7'd0, winscreen}, 8'd0);
    chk("newgame.att", attempts, 8'd3);

    // 5: glitch rejected, then sel+next together acts as sel only
    press(0, 1);
    chk_act("curB2", 2'b00, 2'b01, 2'b00, 2'b00);
    btn_sel = 1'b1;
    repeat (2) @(negedge clk);
    btn_sel = 1'b0;
    repeat (12) @(negedge clk);
    chk_act("glitch", 2'b00, 2'b01, 2'b00, 2'b00);
    chk("glitch.att", attempts, 8'd3);
    press(1, 1);
    chk_act("both", 2'b00, 2'b10, 2'b00, 2'b00);
    press(0, 1);
    chk_act("curC2", 2'b00, 2'b10, 2'b01, 2'b00);
    press(0, 1);
    chk_act("curD2", 2'b00, 2'b10, 2'b00, 2'b01);

    // 6: reset during the mismatch hold
    btn_sel = 1'b1;
    repeat (8) @(negedge clk);
    chk_act("show2", 2'b00, 2'b10, 2'b00, 2'b10);
    chk("show2.att", attempts, 8'd4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_act("rst.show", 2'b01, 2'b00, 2'b00, 2'b00);
    chk("rst.win", {7'd0, winscreen}, 8'd0);
    chk("rst.att", attempts, 8'd0);
    btn_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    press(0, 1);
    chk_act("post.rst", 2'b00, 2'b01, 2'b00, 2'b00);
    chk("post.att", attempts, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
